// File: rtl/dtree_feature_sequencer_pkg.sv
// Shared defaults and types for the decision-tree feature sequencer.
// Class-range checking (DTREE_CLASS_CHECK_EN) compares against NUM_CLASSES below.
package dtree_pkg;
    localparam int DTREE_FEAT_W  = 8;
    localparam int DTREE_CLASS_W = 4;
    localparam int NUM_CLASSES   = 10;
    localparam int SETTLE_W      = 4;

    typedef enum logic [1:0] {IDLE, SETTLE, HOLD} state_e;
    typedef logic [DTREE_CLASS_W-1:0] class_t;
endpackage

// File: rtl/dtree_feature_sequencer_if.sv
// Serial-in, tree-facing and result handshake signals of the feature sequencer.
// slave = sequencer side; master = serial source, tree and result sink side.
interface dtree_feature_sequencer_if
    import dtree_pkg::*;
    #(
        parameter int FEAT_W  = DTREE_FEAT_W,
        parameter int CLASS_W = DTREE_CLASS_W
    );
    logic               ser_in;
    logic               ser_valid;
    logic               ser_ready;
    logic [FEAT_W-1:0]  feat_out;
    logic [CLASS_W-1:0] class_in;
    logic               res_valid;
    logic               res_ready;
    logic [CLASS_W-1:0] res_class;
    logic               res_err;

    modport slave (
        input  ser_in, ser_valid, class_in, res_ready,
        output ser_ready, feat_out, res_valid, res_class, res_err
    );

    modport master (
        output ser_in, ser_valid, class_in, res_ready,
        input  ser_ready, feat_out, res_valid, res_class, res_err
    );
endinterface

// File: rtl/dtree_feature_sequencer_ser_shift.sv
// Bit-serial deserialiser: one bit per accepted cycle, a full word raises pending until consumed.
// ser_ready drops while a completed word waits, so no bit is ever overwritten.
module dtree_ser_shift #(
    parameter int FEAT_W    = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ser_in_i,
    input  logic              ser_valid_i,
    input  logic              consume_i,
    output logic              ser_ready_o,
    output logic [FEAT_W-1:0] shreg_o,
    output logic              pending_o
);
    localparam int CNT_W = (FEAT_W > 1) ? $clog2(FEAT_W) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(FEAT_W - 1);

    logic [FEAT_W-1:0] shreg_q, shreg_d;
    logic [CNT_W-1:0]  bitcnt_q, bitcnt_d;
    logic              pending_q, pending_d;
    logic              accept;

    assign accept = ser_valid_i & ~pending_q;

    always_comb begin
        shreg_d   = shreg_q;
        bitcnt_d  = bitcnt_q;
        pending_d = pending_q;
        if (consume_i) begin
            pending_d = 1'b0;
        end else if (accept) begin
            if (MSB_FIRST) shreg_d = {shreg_q[FEAT_W-2:0], ser_in_i};
            else           shreg_d = {ser_in_i, shreg_q[FEAT_W-1:1]};
            if (bitcnt_q == LAST_BIT) begin
                bitcnt_d  = '0;
                pending_d = 1'b1;
            end else begin
                bitcnt_d = bitcnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shreg_q   <= '0;
            bitcnt_q  <= '0;
            pending_q <= 1'b0;
        end else begin
            shreg_q   <= shreg_d;
            bitcnt_q  <= bitcnt_d;
            pending_q <= pending_d;
        end
    end

    assign ser_ready_o = ~pending_q;
    assign shreg_o     = shreg_q;
    assign pending_o   = pending_q;
endmodule

// File: rtl/dtree_feature_sequencer.sv
// Feeds the printed tree one feature, waits SETTLE_CYC edges, then holds the class on valid/ready.
// Result valid SETTLE_CYC+1 edges after the last bit; DTREE_CLASS_CHECK_EN adds the range flag.
module dtree_feature_sequencer
    import dtree_pkg::*;
    #(
        parameter int FEAT_W     = DTREE_FEAT_W,
        parameter int CLASS_W    = DTREE_CLASS_W,
        parameter int SETTLE_CYC = 2,
        parameter bit MSB_FIRST  = 1'b1
    ) (
        input  logic                       clk,
        input  logic                       rst_n,
        dtree_feature_sequencer_if.slave   bus
    );
    localparam logic [SETTLE_W-1:0] SETTLE_LOAD = SETTLE_W'(SETTLE_CYC - 1);

    state_e              state_q;
    logic [FEAT_W-1:0]   feat_q;
    logic [CLASS_W-1:0]  cls_q;
    logic                vld_q;
    logic [SETTLE_W-1:0] cnt_q;
    logic [FEAT_W-1:0]   shreg;
    logic                pending;
    logic                hold_ack;
    logic                consume;

    dtree_ser_shift #(
        .FEAT_W    (FEAT_W),
        .MSB_FIRST (MSB_FIRST)
    ) u_shift (
        .clk         (clk),
        .rst_n       (rst_n),
        .ser_in_i    (bus.ser_in),
        .ser_valid_i (bus.ser_valid),
        .consume_i   (consume),
        .ser_ready_o (bus.ser_ready),
        .shreg_o     (shreg),
        .pending_o   (pending)
    );

    // A waiting word is taken from IDLE, or straight out of HOLD on the handshake edge.
    assign hold_ack = vld_q & bus.res_ready;
    assign consume  = pending & ((state_q == IDLE) | ((state_q == HOLD) & hold_ack));

`ifdef DTREE_CLASS_CHECK_EN
    logic err_q;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            feat_q  <= '0;
            cls_q   <= '0;
            vld_q   <= 1'b0;
            cnt_q   <= '0;
`ifdef DTREE_CLASS_CHECK_EN
            err_q   <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (pending) begin
                        feat_q  <= shreg;
                        cnt_q   <= SETTLE_LOAD;
                        state_q <= SETTLE;
                    end
                end
                SETTLE: begin
                    if (cnt_q == '0) begin
                        cls_q   <= bus.class_in;
                        vld_q   <= 1'b1;
`ifdef DTREE_CLASS_CHECK_EN
                        err_q   <= (32'(bus.class_in) >= 32'(NUM_CLASSES));
`endif
                        state_q <= HOLD;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                HOLD: begin
                    if (hold_ack) begin
                        vld_q <= 1'b0;
                        if (pending) begin
                            feat_q  <= shreg;
                            cnt_q   <= SETTLE_LOAD;
                            state_q <= SETTLE;
                        end else begin
                            state_q <= IDLE;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.feat_out  = feat_q;
    assign bus.res_class = cls_q;
    assign bus.res_valid = vld_q;
`ifdef DTREE_CLASS_CHECK_EN
    assign bus.res_err   = err_q;
`else
    assign bus.res_err   = 1'b0;
`endif
endmodule

// File: tb/tb_dtree_feature_sequencer.sv
// Bench for dtree_feature_sequencer: MSB-first and LSB-first instances fed the same serial stream.
module tb_dtree_feature_sequencer;
    import dtree_pkg::*;

`ifdef DTREE_CLASS_CHECK_EN
    localparam bit CHK_EN = 1'b1;
`else
    localparam bit CHK_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;
    logic [7:0] cur_feat;
    logic [7:0] q1[$];
    logic [7:0] q2[$];
    logic [7:0] acc1, acc2;
    int         nb;

    typedef struct {
        logic [7:0] feat;
        logic [3:0] cls;
        logic [7:0] rev;
        bit         gap;
    } vec_t;
    vec_t vecs[10];

    dtree_feature_sequencer_if #(.FEAT_W(8), .CLASS_W(4)) ifc ();
    dtree_feature_sequencer_if #(.FEAT_W(8), .CLASS_W(4)) ifc2 ();

    dtree_feature_sequencer #(.FEAT_W(8), .CLASS_W(4), .SETTLE_CYC(2), .MSB_FIRST(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .bus(ifc.slave));
    dtree_feature_sequencer #(.FEAT_W(8), .CLASS_W(4), .SETTLE_CYC(2), .MSB_FIRST(1'b0)) dut_lsb (
        .clk(clk), .rst_n(rst_n), .bus(ifc2.slave));

    always #5 clk = ~clk;

    function automatic class_t tree(input logic [7:0] f);
        if (f == 8'h45) return 4'd7;
        if (f == 8'hF0) return 4'd12;
        return f[7:4] ^ f[3:0];
    endfunction

    function automatic logic exp_err(input class_t c);
        return CHK_EN && (c >= 4'd10);
    endfunction

    assign ifc.class_in   = tree(ifc.feat_out);
    assign ifc2.class_in  = tree(ifc2.feat_out);
    assign ifc2.ser_in    = ifc.ser_in;
    assign ifc2.ser_valid = ifc.ser_valid;
    assign ifc2.res_ready = ifc.res_ready;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h want 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_feat"},  32'(ifc.feat_out),   32'h0);
        chk({tag, "_class"}, 32'(ifc.res_class),  32'h0);
        chk({tag, "_vld"},   32'(ifc.res_valid),  32'h0);
        chk({tag, "_err"},   32'(ifc.res_err),    32'h0);
        chk({tag, "_rdy"},   32'(ifc.ser_ready),  32'h1);
        chk({tag, "_feat2"}, 32'(ifc2.feat_out),  32'h0);
        chk({tag, "_vld2"},  32'(ifc2.res_valid), 32'h0);
    endtask

    // Called at a negedge; returns at the negedge following the edge that took the bit.
    task automatic send_bit(input logic b);
        int n = 0;
        ifc.ser_valid = 1'b1;
        ifc.ser_in    = b;
        while (ifc.ser_ready !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) chk("ser_ready_timeout", 32'(ifc.ser_ready), 32'h1);
        @(negedge clk);
        ifc.ser_valid = 1'b0;
    endtask

    task automatic send_feat(input logic [7:0] f, input bit gap);
        for (int i = 7; i >= 0; i--) begin
            send_bit(f[i]);
            if (gap && i > 0) @(negedge clk);
        end
    endtask

    task automatic run_lat(input logic [7:0] f, input logic [3:0] cls, input logic [7:0] rev, input bit gap);
        send_feat(f, gap);
        chk("feat_not_yet", 32'(ifc.feat_out), 32'(cur_feat));
        @(negedge clk);
        chk("feat_load",     32'(ifc.feat_out),  32'(f));
        chk("feat_load_lsb", 32'(ifc2.feat_out), 32'(rev));
        chk("vld_t1",        32'(ifc.res_valid), 32'h0);
        @(negedge clk);
        chk("vld_t2",        32'(ifc.res_valid), 32'h0);
        @(negedge clk);
        chk("vld_t3",        32'(ifc.res_valid),  32'h1);
        chk("class",         32'(ifc.res_class),  32'(cls));
        chk("err",           32'(ifc.res_err),    32'(exp_err(cls)));
        chk("class_lsb",     32'(ifc2.res_class), 32'(tree(rev)));
        chk("err_lsb",       32'(ifc2.res_err),   32'(exp_err(tree(rev))));
        cur_feat = f;
    endtask

    task automatic hold_release(input logic [3:0] cls);
        repeat (2) @(negedge clk);
        chk("hold_vld",   32'(ifc.res_valid), 32'h1);
        chk("hold_class", 32'(ifc.res_class), 32'(cls));
        chk("hold_feat",  32'(ifc.feat_out),  32'(cur_feat));
        ifc.res_ready = 1'b1;
        @(negedge clk);
        chk("ack_vld", 32'(ifc.res_valid), 32'h0);
        chk("ack_rdy", 32'(ifc.ser_ready), 32'h1);
        ifc.res_ready = 1'b0;
    endtask

    task automatic monitor_cycle();
        if (ifc.res_valid) begin
            if (q1.size() == 0) begin
                chk("spurious_result", 32'(ifc.res_valid), 32'h0);
            end else begin
                chk("rnd_class",     32'(ifc.res_class),  32'(tree(q1[0])));
                chk("rnd_err",       32'(ifc.res_err),    32'(exp_err(tree(q1[0]))));
                chk("rnd_feat",      32'(ifc.feat_out),   32'(q1[0]));
                chk("rnd_vld_lsb",   32'(ifc2.res_valid), 32'h1);
                chk("rnd_class_lsb", 32'(ifc2.res_class), 32'(tree(q2[0])));
                chk("rnd_feat_lsb",  32'(ifc2.feat_out),  32'(q2[0]));
                if (ifc.res_ready) begin
                    void'(q1.pop_front());
                    void'(q2.pop_front());
                end
            end
        end
        if (ifc.ser_valid && ifc.ser_ready) begin
            acc1 = (acc1 * 2) + 8'(ifc.ser_in);
            acc2 = acc2 + (8'(ifc.ser_in) << nb);
            nb++;
            if (nb == 8) begin
                q1.push_back(acc1);
                q2.push_back(acc2);
                nb   = 0;
                acc1 = 8'h0;
                acc2 = 8'h0;
            end
        end
    endtask

    initial begin
        vecs[0] = '{8'hA3, 4'd9,  8'hC5, 1'b1};
        vecs[1] = '{8'hF0, 4'd12, 8'h0F, 1'b0};
        vecs[2] = '{8'h12, 4'd3,  8'h48, 1'b0};
        vecs[3] = '{8'h80, 4'd8,  8'h01, 1'b0};
        vecs[4] = '{8'h01, 4'd1,  8'h80, 1'b1};
        vecs[5] = '{8'h3C, 4'd15, 8'h3C, 1'b0};
        vecs[6] = '{8'h00, 4'd0,  8'h00, 1'b0};
        vecs[7] = '{8'h5A, 4'd15, 8'h5A, 1'b1};
        vecs[8] = '{8'h81, 4'd9,  8'h81, 1'b0};
        vecs[9] = '{8'hC7, 4'd11, 8'hE3, 1'b0};

        rst_n = 1'b0;
        ifc.ser_in = 1'b0;
        ifc.ser_valid = 1'b0;
        ifc.res_ready = 1'b0;
        cur_feat = 8'h0;
        repeat (2) @(negedge clk);
        chk_reset("reset");
        rst_n = 1'b1;
        @(negedge clk);

        // 0x45 result held, 0x12 queues behind it, 0xFF bits stall.
        run_lat(8'h45, 4'd7, 8'hA2, 1'b0);
        send_feat(8'h12, 1'b0);
        chk("bp_rdy",   32'(ifc.ser_ready), 32'h0);
        chk("bp_feat",  32'(ifc.feat_out),  32'h45);
        chk("bp_class", 32'(ifc.res_class), 32'h7);
        chk("bp_vld",   32'(ifc.res_valid), 32'h1);
        ifc.ser_valid = 1'b1;
        ifc.ser_in    = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("bp_stall_rdy", 32'(ifc.ser_ready), 32'h0);
        end
        ifc.ser_valid = 1'b0;
        ifc.res_ready = 1'b1;
        @(negedge clk);
        chk("bp_load_feat",  32'(ifc.feat_out),  32'h12);
        chk("bp_load_vld",   32'(ifc.res_valid), 32'h0);
        chk("bp_load_rdy",   32'(ifc.ser_ready), 32'h1);
        ifc.res_ready = 1'b0;
        @(negedge clk);
        chk("bp_vld_l1",     32'(ifc.res_valid), 32'h0);
        @(negedge clk);
        chk("bp_vld_l2",     32'(ifc.res_valid),  32'h1);
        chk("bp_class2",     32'(ifc.res_class),  32'h3);
        chk("bp_feat2_lsb",  32'(ifc2.feat_out),  32'h48);
        cur_feat = 8'h12;
        hold_release(4'd3);
        run_lat(8'hFF, 4'd0, 8'hFF, 1'b0);
        hold_release(4'd0);

        for (int i = 0; i < 10; i++) begin
            run_lat(vecs[i].feat, vecs[i].cls, vecs[i].rev, vecs[i].gap);
            hold_release(vecs[i].cls);
        end

        // Reset after five bits of 0x3C; the partial word must vanish.
        for (int i = 7; i >= 3; i--) send_bit(vecs[5].feat[i]);
        rst_n = 1'b0;
        #1;
        chk("async_rst_feat", 32'(ifc.feat_out), 32'h0);
        @(negedge clk);
        chk_reset("midshift");
        rst_n = 1'b1;
        @(negedge clk);
        cur_feat = 8'h0;
        run_lat(8'h81, 4'd9, 8'h81, 1'b0);
        hold_release(4'd9);

        // Reset while settling.
        send_feat(8'h5A, 1'b0);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("rst_settle_feat", 32'(ifc.feat_out),  32'h0);
        chk("rst_settle_vld",  32'(ifc.res_valid), 32'h0);
        @(negedge clk);
        @(negedge clk);
        chk("rst_settle_vld2", 32'(ifc.res_valid), 32'h0);
        rst_n = 1'b1;
        @(negedge clk);
        cur_feat = 8'h0;

        acc1 = 8'h0;
        acc2 = 8'h0;
        nb   = 0;
        for (int c = 0; c < 800; c++) begin
            ifc.ser_valid = ($urandom_range(3) != 0);
            ifc.ser_in    = 1'($urandom_range(1));
            ifc.res_ready = ($urandom_range(1) == 1);
            #1;
            monitor_cycle();
            @(negedge clk);
        end
        ifc.ser_valid = 1'b0;
        ifc.res_ready = 1'b1;
        for (int c = 0; c < 60; c++) begin
            #1;
            monitor_cycle();
            @(negedge clk);
        end
        chk("drained", 32'(q1.size()), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
